// File: rtl/pipe_pal_pkg.sv
// Shared constants and helpers for the pipe_pal scheduler slice.
package pipe_pal_pkg;

  localparam int W_DATA_DEF    = 32;
  localparam int MAX_OUT_LIMIT = 7;
  localparam int W_CNT         = 3;

  // Tag width never collapses to zero bits, even for tiny requester counts.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/pipe_pal_sched_rr_arbiter.sv
// Combinational round-robin arbiter: first eligible index scanning from i_ptr upward, wrapping.
module rr_arbiter #(
  parameter int N     = 4,
  parameter int W_IDX = 2
) (
  input  logic [N-1:0]     i_elig,
  input  logic [W_IDX-1:0] i_ptr,
  output logic [N-1:0]     o_gnt_onehot,
  output logic [W_IDX-1:0] o_gnt_idx,
  output logic             o_gnt_any
);

  // Scan from the farthest offset down so the nearest eligible index wins last.
  always_comb begin
    o_gnt_onehot = '0;
    o_gnt_idx    = '0;
    o_gnt_any    = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      if (i_elig[(int'(i_ptr) + k) % N]) begin
        o_gnt_idx = W_IDX'((int'(i_ptr) + k) % N);
        o_gnt_any = 1'b1;
      end
    end
    if (o_gnt_any) o_gnt_onehot[o_gnt_idx] = 1'b1;
  end

endmodule

// File: rtl/pipe_pal_sched.sv
// Round-robin scheduler sharing one pipelined pipe_pal datapath between N_REQ requesters,
// with per-requester credit limits and tagged result return.
module pipe_pal_sched
  import pipe_pal_pkg::*;
#(
  parameter int  W_DATA  = W_DATA_DEF,
  parameter int  N_REQ   = 4,
  parameter int  MAX_OUT = 2,
  localparam int W_TAG   = clog2_min1(N_REQ)
) (
  input  logic                      i_clk,
  input  logic                      resetn,
  input  logic                      i_en,
  input  logic [N_REQ-1:0]          req_valid,
  output logic [N_REQ-1:0]          req_ready,
  input  logic [N_REQ*W_DATA-1:0]   req_a,
  input  logic [N_REQ*W_DATA-1:0]   req_b,
  output logic                      dp_valid,
  output logic [W_DATA-1:0]         dp_a,
  output logic [W_DATA-1:0]         dp_b,
  output logic [W_TAG-1:0]          dp_tag,
  input  logic                      dp_rsp_valid,
  input  logic [W_DATA-1:0]         dp_rsp_data,
  input  logic [W_TAG-1:0]          dp_rsp_tag,
  output logic [N_REQ-1:0]          rsp_valid,
  output logic [W_DATA-1:0]         rsp_data,
  output logic                      idle,
  output logic                      err
);

  logic [N_REQ-1:0]            w_elig;
  logic [N_REQ-1:0]            w_gnt_onehot;
  logic [W_TAG-1:0]            w_gnt_idx;
  logic                        w_gnt_any;
  logic [N_REQ-1:0]            w_rsp_hit;
  logic [N_REQ-1:0]            w_cnt_nz;
  logic [N_REQ-1:0]            w_inc;
  logic [N_REQ-1:0]            w_dec;
  logic [N_REQ-1:0]            w_cnt_next_zero;
  logic [N_REQ-1:0][W_CNT-1:0] w_cnt_next;
  logic                        w_tag_ok;

  logic [N_REQ-1:0][W_CNT-1:0] r_cnt;
  logic [W_TAG-1:0]            r_ptr;
  logic                        r_dp_valid;
  logic [W_DATA-1:0]           r_dp_a;
  logic [W_DATA-1:0]           r_dp_b;
  logic [W_TAG-1:0]            r_dp_tag;
  logic [N_REQ-1:0]            r_rsp_valid;
  logic [W_DATA-1:0]           r_rsp_data;
  logic                        r_idle;
  logic                        r_err;

  assign w_tag_ok = (32'(dp_rsp_tag) < N_REQ);

  // resetn gates eligibility so nothing is offered while the block is held in reset.
  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_credit
    assign w_rsp_hit[gi] = dp_rsp_valid & w_tag_ok & (dp_rsp_tag == W_TAG'(gi));
    assign w_cnt_nz[gi]  = (r_cnt[gi] != '0);
    assign w_elig[gi]    = resetn & i_en & req_valid[gi] & (r_cnt[gi] < W_CNT'(MAX_OUT));
    assign w_inc[gi]     = w_gnt_onehot[gi];
    assign w_dec[gi]     = w_rsp_hit[gi] & w_cnt_nz[gi];
    assign w_cnt_next[gi] = (w_inc[gi] & ~w_dec[gi]) ? r_cnt[gi] + W_CNT'(1) :
                            (~w_inc[gi] & w_dec[gi]) ? r_cnt[gi] - W_CNT'(1) :
                            r_cnt[gi];
    assign w_cnt_next_zero[gi] = (w_cnt_next[gi] == '0);
  end

  rr_arbiter #(
    .N     (N_REQ),
    .W_IDX (W_TAG)
  ) u_arb (
    .i_elig       (w_elig),
    .i_ptr        (r_ptr),
    .o_gnt_onehot (w_gnt_onehot),
    .o_gnt_idx    (w_gnt_idx),
    .o_gnt_any    (w_gnt_any)
  );

  assign req_ready = w_gnt_onehot;

  always_ff @(posedge i_clk or negedge resetn) begin
    if (!resetn) begin
      r_cnt       <= '0;
      r_ptr       <= '0;
      r_dp_valid  <= 1'b0;
      r_dp_a      <= '0;
      r_dp_b      <= '0;
      r_dp_tag    <= '0;
      r_rsp_valid <= '0;
      r_rsp_data  <= '0;
      r_idle      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_cnt      <= w_cnt_next;
      r_dp_valid <= w_gnt_any;
      if (w_gnt_any) begin
        r_dp_a   <= req_a[int'(w_gnt_idx)*W_DATA +: W_DATA];
        r_dp_b   <= req_b[int'(w_gnt_idx)*W_DATA +: W_DATA];
        r_dp_tag <= w_gnt_idx;
        r_ptr    <= (int'(w_gnt_idx) == N_REQ - 1) ? '0 : w_gnt_idx + W_TAG'(1);
      end
      r_rsp_valid <= w_rsp_hit;
      if (|w_rsp_hit) r_rsp_data <= dp_rsp_data;
      // Out-of-range tags are dropped; results for an idle requester still strobe.
      r_err  <= r_err | (dp_rsp_valid & ~w_tag_ok) | (|(w_rsp_hit & ~w_cnt_nz));
      r_idle <= (&w_cnt_next_zero) & ~w_gnt_any;
    end
  end

  assign dp_valid  = r_dp_valid;
  assign dp_a      = r_dp_a;
  assign dp_b      = r_dp_b;
  assign dp_tag    = r_dp_tag;
  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_rsp_data;
  assign idle      = r_idle;
  assign err       = r_err;

endmodule
